// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//
// Divides clk down to a periodic one-cycle tick and hands each tick to one
// of N_CH requesters, chosen round-robin. The divide ratio can be changed at
// any time. While running, a new ratio waits in a one-entry pending slot and
// takes effect at the next wrap, so the period in progress is never cut short.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   en          1 = RUN, 0 = IDLE
//   cfg_valid   new divide ratio offered
//   cfg_div     offered ratio in clk cycles per tick (0 is treated as 1)
//   cfg_ready   configuration slot free (low while a ratio is pending)
//   req         per-channel tick request level, sampled only at wrap edges
//   tick        registered one-cycle tick pulse
//   grant       registered one-hot owner of the current tick, 0 when tick=0
//   div_active  divide ratio currently in force
//   busy        1 while in RUN
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int N_CH        = 4,
  parameter int W           = 32,
  parameter int DEFAULT_DIV = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cfg_valid,
  input  logic [W-1:0]    cfg_div,
  output logic            cfg_ready,
  input  logic [N_CH-1:0] req,
  output logic            tick,
  output logic [N_CH-1:0] grant,
  output logic [W-1:0]    div_active,
  output logic            busy
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // A zero reset ratio would make the wrap compare underflow; saturate to 1.
  localparam logic [W-1:0] RST_DIV = (DEFAULT_DIV == 0) ? W'(1) : W'(DEFAULT_DIV);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e          state_q,    state_d;
  logic [W-1:0]    count_q,    count_d;
  logic [PW-1:0]   ptr_q,      ptr_d;
  logic            pend_vld_q, pend_vld_d;
  logic [W-1:0]    pend_div_q, pend_div_d;
  logic [W-1:0]    div_q,      div_d;
  logic            tick_q,     tick_d;
  logic [N_CH-1:0] grant_q,    grant_d;

  logic            cfg_fire;
  logic [W-1:0]    cfg_sat;
  logic            wrap;
  logic            arb_hit;
  logic [PW-1:0]   arb_idx;
  logic [PW-1:0]   ptr_next;

  // Channel index 'offs' places after 'base', modulo N_CH (N_CH need not be
  // a power of two, so plain PW-bit wraparound is not enough).
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_CH) sum = sum - N_CH;
    return PW'(sum);
  endfunction

  assign cfg_fire = cfg_valid & ~pend_vld_q;
  assign cfg_sat  = (cfg_div == '0) ? W'(1) : cfg_div;
  assign wrap     = (count_q == div_q - W'(1));

  // Round-robin search. Walking from the lowest-priority offset down to the
  // pointer lets the last hit win, which is the first requester at or after
  // ptr_q, without a separate "already found" flag.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[rot_idx(ptr_q, i)]) begin
        arb_hit = 1'b1;
        arb_idx = rot_idx(ptr_q, i);
      end
    end
  end

  assign ptr_next = (arb_idx == PW'(N_CH - 1)) ? '0 : arb_idx + PW'(1);

  // Next-state and registered-output logic.
  // NOTE: every signal gets its default before the case; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    div_d      = div_q;
    tick_d     = 1'b0;
    grant_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        // No period is running, so a new ratio applies immediately.
        if (cfg_fire) div_d = cfg_sat;
        if (en) begin
          state_d = S_RUN;
          count_d = '0;
        end
      end

      S_RUN: begin
        if (!en) begin
          // Leaving RUN beats a coinciding wrap: no tick, and whatever ratio
          // is waiting (or arriving on this edge) is put into force now.
          state_d = S_IDLE;
          count_d = '0;
          if (pend_vld_q) begin
            div_d      = pend_div_q;
            pend_vld_d = 1'b0;
          end else if (cfg_fire) begin
            div_d = cfg_sat;
          end
        end else if (wrap) begin
          count_d = '0;
          tick_d  = 1'b1;
          if (arb_hit) begin
            grant_d = N_CH'(1) << arb_idx;
            ptr_d   = ptr_next;
          end
          if (pend_vld_q) begin
            div_d      = pend_div_q;
            pend_vld_d = 1'b0;
          end
          // cfg_fire implies the slot was empty, so this never collides
          // with the release above. A ratio taken on a wrap edge governs
          // the period after the one starting now.
          if (cfg_fire) begin
            pend_vld_d = 1'b1;
            pend_div_d = cfg_sat;
          end
        end else begin
          count_d = count_q + W'(1);
          if (cfg_fire) begin
            pend_vld_d = 1'b1;
            pend_div_d = cfg_sat;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ptr_q      <= '0;
      pend_vld_q <= 1'b0;
      div_q      <= RST_DIV;
      tick_q     <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      pend_vld_q <= pend_vld_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      grant_q    <= grant_d;
    end
  end

  // NOTE: the pending ratio is payload qualified by pend_vld_q, which is
  // reset; the data itself needs no reset and is kept off the reset tree.
  always_ff @(posedge clk) begin
    pend_div_q <= pend_div_d;
  end

  assign cfg_ready  = ~pend_vld_q;
  assign tick       = tick_q;
  assign grant      = grant_q;
  assign div_active = div_q;
  assign busy       = (state_q == S_RUN);

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, giving the number of tick requesters (2..8).
REQ-002 The module SHALL have parameter W, default 32, giving the divide-count width.
REQ-003 The module SHALL have parameter DEFAULT_DIV, default 5, giving the divide ratio loaded at reset.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  1  run enable: 1 = RUN, 0 = IDLE.
REQ-007 Port cfg_valid  input  1  new divide ratio offered.
REQ-008 Port cfg_div  input  W  offered divide ratio, in clk cycles per tick.
REQ-009 Port cfg_ready  output  1  configuration slot free; a transfer occurs when cfg_valid and cfg_ready are both 1 at a clk edge.
REQ-010 Port req  input  N_CH  per-channel tick request level.
REQ-011 Port tick  output  1  registered one-cycle tick pulse.
REQ-012 Port grant  output  N_CH  registered one-hot owner of the current tick; all zeros when tick=0.
REQ-013 Port div_active  output  W  divide ratio currently in force.
REQ-014 Port busy  output  1  1 while in RUN.

Function
REQ-015 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-016 Transitions SHALL be: IDLE->RUN when en=1 at an edge, which also sets count=0; RUN->IDLE when en=0 at an edge, which also sets count=0, tick=0 and grant=0.
REQ-017 In RUN, each edge SHALL do one of two things: if count==div_active-1, set count<=0 and tick<=1; otherwise set count<=count+1 and tick<=0.
REQ-018 The first tick SHALL therefore appear div_active cycles after the edge that enters RUN, then every div_active cycles, each pulse exactly one cycle wide.
REQ-019 tick SHALL stay 0 in IDLE.
REQ-020 A cfg_div of 0 SHALL be stored as 1, so div_active is never 0.
REQ-021 div_active=1 SHALL give tick=1 on every cycle in RUN.
REQ-022 In IDLE, an accepted cfg SHALL update div_active at the accepting edge.
REQ-023 In RUN, an accepted cfg SHALL go into a one-entry pending register.
- cfg_ready SHALL be 0 while that register is occupied.
- The pending value SHALL be copied into div_active, and the register freed, at the wrap edge (the edge that sets tick=1).
- The new ratio SHALL therefore govern the next full period; the current period is never shortened.
REQ-024 On RUN->IDLE, a pending value SHALL be applied to div_active at the same edge.
REQ-025 If en=0 coincides with a wrap, IDLE SHALL win: no tick, and pending applied per REQ-024.
REQ-026 Round-robin arbitration: a pointer ptr (0..N_CH-1) SHALL name the highest-priority channel.
- At each wrap edge, grant SHALL be set one-hot to the first channel with req=1, searching ptr, ptr+1, ... modulo N_CH.
- ptr SHALL then become (granted index + 1) mod N_CH.
REQ-027 If req is all zeros at a wrap edge, tick SHALL still pulse, grant SHALL be 0, and ptr SHALL be unchanged.
REQ-028 req SHALL be sampled only at wrap edges; changes to req between ticks SHALL have no effect.
REQ-029 grant SHALL never have more than one bit set.
REQ-030 Latency:
- cfg acceptance -> div_active: 0 cycles in IDLE; up to div_active cycles in RUN.
- req -> grant: at the next wrap edge.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force:
- state=IDLE, count=0, ptr=0, pending empty;
- div_active=DEFAULT_DIV (saturated to 1 if 0);
- tick=0, grant=0, busy=0, cfg_ready=1.
REQ-032 Reset asserted mid-period SHALL discard the pending cfg and any partial count.
REQ-033 After rst rises, the block SHALL need one edge with en=1 to enter RUN.

Verification
REQ-034 Reset, en=1, req=0: ticks at cycles 5, 10, 15 after RUN entry; grant=0; div_active=5.
REQ-035 div 4, req=4'b1011 held: grants cycle 0001, 0010, 1000, 0001; ptr wraps from 3 to 0.
REQ-036 RUN with div 5, cfg_div=2 accepted at count=1:
- cfg_ready drops to 0;
- the tick still occurs 5 cycles after the previous one;
- ticks then every 2 cycles;
- cfg_ready returns to 1 at that wrap.
REQ-037 In IDLE, cfg_div=0 accepted: div_active=1; then en=1 gives tick on every cycle.
REQ-038 en drops on the exact wrap cycle with cfg 7 pending: no tick, busy=0, div_active=7 at that edge.
REQ-039 rst pulsed low mid-period with cfg pending: all outputs return to reset values immediately; div_active=5; cfg_ready=1.
